// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// over a shared datapath and decodes per-state enables and mux selects.
module mc_ctrl #(
    parameter int NOP_FAST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_we,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       ext_op,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] npc_sel,
    output logic       retire,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE_R   = 4'd2,
        S_WB_R    = 4'd3,
        S_EXE_I   = 4'd4,
        S_WB_I    = 4'd5,
        S_MEM_ADR = 4'd6,
        S_MEM_RD  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_MEM_WR  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    state_t state_q, state_d;

    logic is_rtype, is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    assign is_rtype = (op == 6'h00);
    assign is_addu  = is_rtype && (funct == 6'h21);
    assign is_subu  = is_rtype && (funct == 6'h23);
    assign is_jr    = is_rtype && (funct == 6'h08);
    assign is_ori   = (op == 6'h0D);
    assign is_lui   = (op == 6'h0F);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);

    logic       pc_we_c, ir_we_c, reg_we_c, mem_we_c, retire_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_we_c    = 1'b0;
        ir_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        mem_we_c   = 1'b0;
        retire_c   = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        ext_op     = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        npc_sel    = 2'd0;

        case (state_q)
            S_FETCH: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_addu || is_subu) begin
                    state_d = S_EXE_R;
                end else if (is_jr || is_j || is_jal) begin
                    state_d = S_JUMP;
                end else if (is_ori || is_lui) begin
                    state_d = S_EXE_I;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM_ADR;
                end else if (is_beq) begin
                    state_d = S_BRANCH;
                end else if (NOP_FAST != 0) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXE_R;
                end
            end
            S_EXE_R: begin
                alu_op  = is_subu ? ALU_SUB : ALU_ADD;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                // Undecoded words reach here when NOP_FAST=0; they retire without writing.
                reg_we_c = is_addu || is_subu;
                reg_dst  = 2'd1;
                alu_op   = is_subu ? ALU_SUB : ALU_ADD;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXE_I: begin
                alu_src_b = 1'b1;
                alu_op    = is_lui ? ALU_LUI : ALU_OR;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_we_c = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_ADR: begin
                alu_src_b = 1'b1;
                ext_op    = 1'b1;
                state_d   = is_sw ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                alu_src_b = 1'b1;
                ext_op    = 1'b1;
                state_d   = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_we_c   = 1'b1;
                mem_to_reg = 2'd1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_we_c  = 1'b1;
                alu_src_b = 1'b1;
                ext_op    = 1'b1;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = ALU_SUB;
                npc_sel  = 2'd1;
                pc_we_c  = zero;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_we_c  = 1'b1;
                npc_sel  = is_jr ? 2'd3 : 2'd2;
                retire_c = 1'b1;
                if (is_jal) begin
                    reg_we_c   = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset is asynchronous, so enables are gated directly to block writes while it is held.
    assign pc_we  = pc_we_c  & ~reset;
    assign ir_we  = ir_we_c  & ~reset;
    assign reg_we = reg_we_c & ~reset;
    assign mem_we = mem_we_c & ~reset;
    assign retire = retire_c & ~reset;
    assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class through its
// state sequence and compares all outputs against hand-computed vectors.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pc_we, ir_we, reg_we, mem_we, alu_src_b, ext_op, retire;
    logic [1:0] alu_op, reg_dst, mem_to_reg, npc_sel;
    logic [3:0] state;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef logic [18:0] vec_t;

    mc_ctrl #(.NOP_FAST(1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .npc_sel(npc_sel),
        .retire(retire), .state(state)
    );

    always #5 clk = ~clk;

    // Field order: state, pc_we, ir_we, reg_we, mem_we, alu_src_b, alu_op,
    // ext_op, reg_dst, mem_to_reg, npc_sel, retire.
    function automatic vec_t ev(input logic [3:0] s, input logic pc, input logic ir,
                                input logic rw, input logic mw, input logic asb,
                                input logic [1:0] aop, input logic ext, input logic [1:0] rd,
                                input logic [1:0] m2r, input logic [1:0] npc, input logic ret);
        return {s, pc, ir, rw, mw, asb, aop, ext, rd, m2r, npc, ret};
    endfunction

    function automatic vec_t obs();
        return {state, pc_we, ir_we, reg_we, mem_we, alu_src_b, alu_op,
                ext_op, reg_dst, mem_to_reg, npc_sel, retire};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t V_FETCH, V_DECODE, V_IDLE;

    task automatic test_reset();
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
        step();
        total_cnt++;
        if (obs() !== V_IDLE) $display("FAIL reset_hold obs=%h exp=%h", obs(), V_IDLE);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (obs() !== V_FETCH) $display("FAIL reset_release obs=%h exp=%h", obs(), V_FETCH);
        else pass_cnt++;
        // Assert reset mid-DECODE, between edges: state must drop at once.
        step();
        reset = 1'b1;
        #1;
        total_cnt++;
        if (obs() !== V_IDLE) $display("FAIL reset_async obs=%h exp=%h", obs(), V_IDLE);
        else pass_cnt++;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_rtype();
        vec_t exp_q[$];
        op = 6'h00; funct = 6'h21;
        exp_q = '{V_FETCH, V_DECODE,
                  ev(4'd2,0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,0),
                  ev(4'd3,0,0,1,0,0,2'd0,0,2'd1,2'd0,2'd0,1),
                  V_FETCH};
        foreach (exp_q[i]) begin
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL addu_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
        funct = 6'h23;
        exp_q = '{V_FETCH, V_DECODE,
                  ev(4'd2,0,0,0,0,0,2'd1,0,2'd0,2'd0,2'd0,0),
                  ev(4'd3,0,0,1,0,0,2'd1,0,2'd1,2'd0,2'd0,1),
                  V_FETCH};
        foreach (exp_q[i]) begin
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL subu_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
    endtask

    task automatic test_itype();
        vec_t exp_q[$];
        op = 6'h0D; funct = 6'h21;
        exp_q = '{V_FETCH, V_DECODE,
                  ev(4'd4,0,0,0,0,1,2'd2,0,2'd0,2'd0,2'd0,0),
                  ev(4'd5,0,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,1),
                  V_FETCH};
        foreach (exp_q[i]) begin
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL ori_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
        op = 6'h0F;
        exp_q = '{V_FETCH, V_DECODE,
                  ev(4'd4,0,0,0,0,1,2'd3,0,2'd0,2'd0,2'd0,0),
                  ev(4'd5,0,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,1),
                  V_FETCH};
        foreach (exp_q[i]) begin
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL lui_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
    endtask

    task automatic test_load_store();
        vec_t exp_q[$];
        op = 6'h23; funct = 6'h00;
        exp_q = '{V_FETCH, V_DECODE,
                  ev(4'd6,0,0,0,0,1,2'd0,1,2'd0,2'd0,2'd0,0),
                  ev(4'd7,0,0,0,0,1,2'd0,1,2'd0,2'd0,2'd0,0),
                  ev(4'd8,0,0,1,0,0,2'd0,0,2'd0,2'd1,2'd0,1),
                  V_FETCH};
        foreach (exp_q[i]) begin
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL lw_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
        op = 6'h2B;
        exp_q = '{V_FETCH, V_DECODE,
                  ev(4'd6,0,0,0,0,1,2'd0,1,2'd0,2'd0,2'd0,0),
                  ev(4'd9,0,0,0,1,1,2'd0,1,2'd0,2'd0,2'd0,1),
                  V_FETCH};
        foreach (exp_q[i]) begin
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL sw_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
    endtask

    task automatic test_branch();
        vec_t taken, not_taken;
        taken     = ev(4'd10,1,0,0,0,0,2'd1,0,2'd0,2'd0,2'd1,1);
        not_taken = ev(4'd10,0,0,0,0,0,2'd1,0,2'd0,2'd0,2'd1,1);
        op = 6'h04; funct = 6'h00; zero = 1'b1;
        step();
        step();
        total_cnt++;
        if (obs() !== taken) $display("FAIL beq_taken obs=%h exp=%h", obs(), taken);
        else pass_cnt++;
        // pc_we follows zero combinationally within BRANCH.
        zero = 1'b0;
        #1;
        total_cnt++;
        if (obs() !== not_taken) $display("FAIL beq_mealy obs=%h exp=%h", obs(), not_taken);
        else pass_cnt++;
        step();
        total_cnt++;
        if (obs() !== V_FETCH) $display("FAIL beq_end obs=%h exp=%h", obs(), V_FETCH);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (obs() !== not_taken) $display("FAIL beq_not_taken obs=%h exp=%h", obs(), not_taken);
        else pass_cnt++;
        step();
    endtask

    task automatic test_jump();
        vec_t exp_q[$];
        op = 6'h03; funct = 6'h00;
        exp_q = '{V_FETCH, V_DECODE, ev(4'd11,1,0,1,0,0,2'd0,0,2'd2,2'd2,2'd2,1), V_FETCH};
        foreach (exp_q[i]) begin
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL jal_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
        op = 6'h02;
        exp_q = '{V_FETCH, V_DECODE, ev(4'd11,1,0,0,0,0,2'd0,0,2'd0,2'd0,2'd2,1), V_FETCH};
        foreach (exp_q[i]) begin
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL j_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
        op = 6'h00; funct = 6'h08;
        exp_q = '{V_FETCH, V_DECODE, ev(4'd11,1,0,0,0,0,2'd0,0,2'd0,2'd0,2'd3,1), V_FETCH};
        foreach (exp_q[i]) begin
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL jr_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
    endtask

    task automatic test_nop_unknown();
        vec_t exp_q[$];
        vec_t dec_ret;
        dec_ret = ev(4'd1,0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,1);
        op = 6'h00; funct = 6'h00;
        exp_q = '{V_FETCH, dec_ret, V_FETCH, dec_ret, V_FETCH};
        foreach (exp_q[i]) begin
            // Switch to unknown op 0x3F for the second instruction.
            if (i == 2) op = 6'h3F;
            #0;
            total_cnt++;
            if (obs() !== exp_q[i]) $display("FAIL nop_unk_c%0d obs=%h exp=%h", i, obs(), exp_q[i]);
            else pass_cnt++;
            if (i < exp_q.size() - 1) step();
        end
    endtask

    task automatic test_reset_mid();
        op = 6'h23; funct = 6'h00;
        step();
        step();
        step();
        total_cnt++;
        if (state !== 4'd7) $display("FAIL rst_mid_memrd state=%0d exp=7", state);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (obs() !== V_IDLE) $display("FAIL rst_mid_abort obs=%h exp=%h", obs(), V_IDLE);
        else pass_cnt++;
        step();
        total_cnt++;
        if (state === 4'd8 || reg_we !== 1'b0) $display("FAIL rst_mid_nowb state=%0d reg_we=%b exp state=0 reg_we=0", state, reg_we);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (obs() !== V_FETCH) $display("FAIL rst_mid_release obs=%h exp=%h", obs(), V_FETCH);
        else pass_cnt++;
    endtask

    initial begin
        V_FETCH  = ev(4'd0,1,1,0,0,0,2'd0,0,2'd0,2'd0,2'd0,0);
        V_DECODE = ev(4'd1,0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,0);
        V_IDLE   = ev(4'd0,0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,0);
        test_reset();
        test_rtype();
        test_itype();
        test_load_store();
        test_branch();
        test_jump();
        test_nop_unknown();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
